// File: rtl/logit_argmax_if.sv
// Logit stream in, argmax result out, between the accumulator side and the argmax block.
interface logit_argmax_if #(
    parameter int IDX_WIDTH = 7
);
    logic                 start;
    logic                 logit_valid;
    logic [15:0]          logit_data;
    logic                 logit_last;
    logic                 busy;
    logic [IDX_WIDTH-1:0] token;
    logic [15:0]          token_max;
    logic                 token_valid;
    logic                 len_error;
    logic                 nan_only;

    modport master (
        output start, logit_valid, logit_data, logit_last,
        input  busy, token, token_max, token_valid, len_error, nan_only
    );

    modport slave (
        input  start, logit_valid, logit_data, logit_last,
        output busy, token, token_max, token_valid, len_error, nan_only
    );
endinterface

// File: rtl/logit_argmax.sv
// Streaming argmax over one FP16 logit per vocabulary token; NaNs are never selected,
// ties keep the lowest index, and short/long streams are flagged.
module logit_argmax #(
    parameter int NUM_TOKENS = 128,
    parameter int IDX_WIDTH  = 7
) (
    input  logic           clk,
    input  logic           reset,
    logit_argmax_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [IDX_WIDTH:0] LAST_IDX = (IDX_WIDTH+1)'(NUM_TOKENS - 1);

    state_e               state_q, state_d;
    logic [IDX_WIDTH:0]   cnt_q, cnt_d;
    logic                 have_best_q, have_best_d;
    logic [15:0]          best_key_q, best_key_d;
    logic [15:0]          best_val_q, best_val_d;
    logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
    logic [IDX_WIDTH-1:0] token_q, token_d;
    logic [15:0]          token_max_q, token_max_d;
    logic                 len_error_q, len_error_d;
    logic                 nan_only_q, nan_only_d;

    logic [15:0] canon;
    logic [15:0] key;
    logic        is_nan;
    logic        take;

    // Negative zero folds onto +0 so both compare equal and store as 0x0000.
    assign canon  = (bus.logit_data == 16'h8000) ? 16'h0000 : bus.logit_data;
    assign is_nan = (&canon[14:10]) && (|canon[9:0]);
    assign key    = canon[15] ? ~canon : (canon | 16'h8000);
    assign take   = !is_nan && (!have_best_q || (key > best_key_q));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        have_best_d = have_best_q;
        best_key_d  = best_key_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        token_d     = token_q;
        token_max_d = token_max_q;
        len_error_d = len_error_q;
        nan_only_d  = nan_only_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_SCAN;
                    cnt_d       = '0;
                    have_best_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (bus.start) begin
                    cnt_d       = '0;
                    have_best_d = 1'b0;
                end else if (bus.logit_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (take) begin
                        have_best_d = 1'b1;
                        best_key_d  = key;
                        best_val_d  = canon;
                        best_idx_d  = cnt_q[IDX_WIDTH-1:0];
                    end
                    // Results are latched on the exit edge so they are visible in DONE.
                    if (bus.logit_last || (cnt_q == LAST_IDX)) begin
                        state_d     = ST_DONE;
                        len_error_d = !(bus.logit_last && (cnt_q == LAST_IDX));
                        nan_only_d  = !have_best_d;
                        if (have_best_d) begin
                            token_d     = best_idx_d;
                            token_max_d = best_val_d;
                        end else begin
                            token_d     = '0;
                            token_max_d = 16'h7E00;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_d     = ST_SCAN;
                    cnt_d       = '0;
                    have_best_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            have_best_q <= 1'b0;
            best_key_q  <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            token_q     <= '0;
            token_max_q <= 16'h0000;
            len_error_q <= 1'b0;
            nan_only_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            have_best_q <= have_best_d;
            best_key_q  <= best_key_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            token_q     <= token_d;
            token_max_q <= token_max_d;
            len_error_q <= len_error_d;
            nan_only_q  <= nan_only_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.token_valid = (state_q == ST_DONE);
    assign bus.token       = token_q;
    assign bus.token_max   = token_max_q;
    assign bus.len_error   = len_error_q;
    assign bus.nan_only    = nan_only_q;
endmodule

// File: tb/tb_logit_argmax.sv
// Bench for logit_argmax: directed streams on a 4-token instance, random streams on a
// 128-token instance, all checked against a real-valued argmax model.
module tb_logit_argmax;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_r   = 1'b1;
    logic        sel     = 1'b0;   // 0: 4-token instance, 1: 128-token instance
    logic        start_r = 1'b0;
    logic        valid_r = 1'b0;
    logic [15:0] data_r  = '0;
    logic        last_r  = 1'b0;

    int checks   = 0;
    int failures = 0;

    logit_argmax_if #(.IDX_WIDTH(2)) bus4 ();
    logit_argmax_if #(.IDX_WIDTH(7)) bus128 ();

    assign bus4.start         = start_r & ~sel;
    assign bus4.logit_valid   = valid_r & ~sel;
    assign bus4.logit_data    = data_r;
    assign bus4.logit_last    = last_r;
    assign bus128.start       = start_r & sel;
    assign bus128.logit_valid = valid_r & sel;
    assign bus128.logit_data  = data_r;
    assign bus128.logit_last  = last_r;

    logit_argmax #(.NUM_TOKENS(4), .IDX_WIDTH(2)) dut4 (
        .clk   (clk),
        .reset (rst_r),
        .bus   (bus4)
    );

    logit_argmax #(.NUM_TOKENS(128), .IDX_WIDTH(7)) dut128 (
        .clk   (clk),
        .reset (rst_r),
        .bus   (bus128)
    );

    logic [31:0] obs_busy, obs_tv, obs_token, obs_max, obs_len, obs_nan;
    always_comb begin
        obs_busy  = sel ? 32'(bus128.busy)        : 32'(bus4.busy);
        obs_tv    = sel ? 32'(bus128.token_valid) : 32'(bus4.token_valid);
        obs_token = sel ? 32'(bus128.token)       : 32'(bus4.token);
        obs_max   = sel ? 32'(bus128.token_max)   : 32'(bus4.token_max);
        obs_len   = sel ? 32'(bus128.len_error)   : 32'(bus4.len_error);
        obs_nan   = sel ? 32'(bus128.nan_only)    : 32'(bus4.nan_only);
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit fp16_is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    // Exact numeric value of a non-NaN half; infinities map beyond the finite range.
    function automatic real fp16_to_real(input logic [15:0] x);
        real v;
        int  e;
        e = int'(x[14:10]);
        if (e == 31) begin
            v = 1.0e30;
        end else begin
            v = (e == 0) ? real'(x[9:0]) : real'(1024 + int'(x[9:0]));
            if (e == 0) e = 1;
            for (int k = 0; k < 25 - e; k++) v = v / 2.0;
            for (int k = 0; k < e - 25; k++) v = v * 2.0;
        end
        return x[15] ? -v : v;
    endfunction

    task automatic ref_model(input logic [15:0] acc[$], input bit ended_last, input int n_tok,
                             output int tok, output logic [15:0] mx, output bit nan_o, output bit len_e);
        bit  have = 1'b0;
        real best = 0.0;
        tok = 0;
        mx  = 16'h7E00;
        for (int i = 0; i < acc.size(); i++) begin
            if (!fp16_is_nan(acc[i])) begin
                if (!have || fp16_to_real(acc[i]) > best) begin
                    have = 1'b1;
                    best = fp16_to_real(acc[i]);
                    tok  = i;
                    mx   = (acc[i] == 16'h8000) ? 16'h0000 : acc[i];
                end
            end
        end
        nan_o = !have;
        len_e = !ended_last || (acc.size() != n_tok);
    endtask

    // Runs one stream; returns at the DONE cycle when chain is set, with start raised there.
    task automatic run_stream(input string tag, input logic [15:0] vals[$], input int last_pos,
                              input bit gaps, input bit pre_started, input bit chain);
        logic [15:0] acc[$];
        int          cnt_end, exp_tok;
        logic [15:0] exp_max;
        bit          exp_nan, exp_len, ended_last;
        ended_last = (last_pos >= 0);
        cnt_end    = ended_last ? last_pos + 1 : vals.size();
        for (int i = 0; i < cnt_end; i++) acc.push_back(vals[i]);
        ref_model(acc, ended_last, sel ? 128 : 4, exp_tok, exp_max, exp_nan, exp_len);

        if (!pre_started) start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        check_value({tag, ".busy_rise"}, obs_busy, 32'd1);
        for (int i = 0; i < cnt_end; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    valid_r = 1'b0;
                    data_r  = 16'($urandom);
                    last_r  = 1'($urandom);
                    @(negedge clk);
                end
            end
            valid_r = 1'b1;
            data_r  = vals[i];
            last_r  = (i == last_pos);
            @(negedge clk);
            if (i != cnt_end - 1) check_value({tag, ".tv_early"}, obs_tv, 32'd0);
        end
        valid_r = 1'b0;
        last_r  = 1'b0;
        check_value({tag, ".tv"},    obs_tv,    32'd1);
        check_value({tag, ".token"}, obs_token, 32'(exp_tok));
        check_value({tag, ".max"},   obs_max,   32'(exp_max));
        check_value({tag, ".len"},   obs_len,   32'(exp_len));
        check_value({tag, ".nan"},   obs_nan,   32'(exp_nan));
        if (chain) begin
            start_r = 1'b1;
        end else begin
            @(negedge clk);
            check_value({tag, ".tv_fall"},   obs_tv,    32'd0);
            check_value({tag, ".busy_fall"}, obs_busy,  32'd0);
            check_value({tag, ".hold"},      obs_token, 32'(exp_tok));
        end
    endtask

    function automatic logic [15:0] rand_fp16(input int nan_pct);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < nan_pct)      return {1'($urandom), 5'h1F, 10'($urandom_range(1, 1023))};
        if (r < nan_pct + 4)  return {1'($urandom), 15'h7C00};
        if (r < nan_pct + 8)  return {1'($urandom), 15'h0000};
        return {1'($urandom), 5'($urandom_range(0, 30)), 10'($urandom)};
    endfunction

    initial begin
        logic [15:0] q[$];
        logic [15:0] base_a[$];
        int          mode, lp;

        base_a = '{16'h3C00, 16'h4200, 16'hC000, 16'h4000};
        repeat (3) @(negedge clk);
        rst_r = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_value($sformatf("reset%0d.busy", s),  obs_busy,  32'd0);
            check_value($sformatf("reset%0d.tv", s),    obs_tv,    32'd0);
            check_value($sformatf("reset%0d.token", s), obs_token, 32'd0);
            check_value($sformatf("reset%0d.max", s),   obs_max,   32'h0000);
            check_value($sformatf("reset%0d.len", s),   obs_len,   32'd0);
            check_value($sformatf("reset%0d.nan", s),   obs_nan,   32'd0);
        end
        sel = 1'b0;
        @(negedge clk);

        run_stream("basic", base_a, 3, 1'b0, 1'b0, 1'b0);
        q = '{16'h8000, 16'h0000, 16'hBC00, 16'h0000};
        run_stream("zeros", q, 3, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a scan drops the stream and restores reset outputs.
        run_stream("pre_rst", base_a, 3, 1'b0, 1'b0, 1'b0);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        valid_r = 1'b1;
        data_r  = 16'h7800;
        @(negedge clk);
        rst_r = 1'b1;
        @(negedge clk);
        rst_r   = 1'b0;
        valid_r = 1'b0;
        check_value("midrst.busy",  obs_busy,  32'd0);
        check_value("midrst.tv",    obs_tv,    32'd0);
        check_value("midrst.token", obs_token, 32'd0);
        check_value("midrst.max",   obs_max,   32'h0000);
        check_value("midrst.len",   obs_len,   32'd0);
        check_value("midrst.nan",   obs_nan,   32'd0);
        @(negedge clk);
        check_value("midrst.tv2",   obs_tv,    32'd0);
        start_r = 1'b1;
        rst_r   = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        rst_r   = 1'b0;
        check_value("start_rst.busy", obs_busy, 32'd0);
        @(negedge clk);
        check_value("start_rst.busy2", obs_busy, 32'd0);

        q = '{16'h7E01, 16'hFC00, 16'h7C00, 16'h3C00};
        run_stream("naninf", q, 3, 1'b0, 1'b0, 1'b0);
        q = '{16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00};
        run_stream("allnan", q, 3, 1'b0, 1'b0, 1'b0);
        run_stream("short", base_a, 2, 1'b0, 1'b0, 1'b0);
        run_stream("nolast", base_a, -1, 1'b0, 1'b0, 1'b0);

        // Logits offered while idle must not start or complete anything.
        for (int i = 0; i < 3; i++) begin
            valid_r = 1'b1;
            last_r  = 1'b1;
            data_r  = 16'h7BFF;
            @(negedge clk);
            check_value("idle.tv",    obs_tv,    32'd0);
            check_value("idle.busy",  obs_busy,  32'd0);
            check_value("idle.token", obs_token, 32'd1);
        end
        valid_r = 1'b0;
        last_r  = 1'b0;
        @(negedge clk);

        run_stream("gaps", base_a, 3, 1'b1, 1'b0, 1'b0);

        // Restart mid-stream: the large early logits must be forgotten.
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        valid_r = 1'b1;
        data_r  = 16'h7B00;
        @(negedge clk);
        data_r  = 16'h7A00;
        @(negedge clk);
        valid_r = 1'b0;
        run_stream("restart", base_a, 3, 1'b0, 1'b0, 1'b0);

        // Back-to-back: start raised in the DONE cycle.
        run_stream("b2b_first", base_a, 3, 1'b0, 1'b0, 1'b1);
        q = '{16'hC400, 16'hC200, 16'h3800, 16'hB800};
        run_stream("b2b_second", q, 3, 1'b0, 1'b1, 1'b0);

        sel = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 300; s++) begin
            mode = int'($urandom_range(0, 19));
            q.delete();
            for (int i = 0; i < 128; i++) q.push_back(rand_fp16(mode == 0 ? 100 : 10));
            lp = 127;
            if (mode == 1) lp = int'($urandom_range(0, 126));
            if (mode == 2) lp = -1;
            run_stream($sformatf("rand%0d", s), q, lp, mode == 3, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
